// File: rtl/float_struct_pkg.sv
// Shared float types and constants for the adder / normalize-round pipeline.
package float_struct;

  typedef enum logic [1:0] {
    OK  = 2'b00,
    NAN = 2'b01,
    INF = 2'b10,
    NUL = 2'b11
  } states;

  localparam int          EXP_MAX = 255;
  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // Raw adder result: carry, hidden bit, 23-bit fraction, then guard/round/sticky.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    states       st;
  } sum_t;

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero count; an all-zero input reports WIDTH.
module leading_zero_counter #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]           i_data,
  output logic [$clog2(WIDTH+1)-1:0] o_count
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    o_count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/shift_reg_base.sv
// Generic synchronous-reset shift register, STAGES deep, WIDTH bits wide.
module shift_reg_base #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_pipe;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/fp_normalize_round.sv
// Normalize, round-to-nearest-even and pack an adder sum into IEEE-754 single.
module fp_normalize_round
  import float_struct::*;
#(
  parameter int STAGES = 3,
  parameter int MANT_W = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sum_sign,
  input  logic [7:0]        sum_exp,
  input  logic [MANT_W-1:0] sum_mant,
  input  logic [1:0]        in_state,
  input  logic              arg_vld,
  output logic [31:0]       result,
  output logic [1:0]        state,
  output logic              res_vld
);

  localparam logic signed [9:0] EXP_LIM = 10'(EXP_MAX);

  // ---------------- S1: capture ----------------
  logic [4:0] w_lzc;
  sum_t       r1_sum;
  logic [4:0] r1_lzc;
  logic       r1_carry;
  logic       r1_zero;

  leading_zero_counter #(.WIDTH(27)) u_lzc (
    .i_data  (sum_mant[26:0]),
    .o_count (w_lzc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_sum   <= '0;
      r1_lzc   <= '0;
      r1_carry <= 1'b0;
      r1_zero  <= 1'b0;
    end else if (arg_vld) begin
      r1_sum   <= '{sign: sum_sign, exp: sum_exp, mant: sum_mant, st: states'(in_state)};
      r1_lzc   <= w_lzc;
      r1_carry <= sum_mant[27];
      r1_zero  <= (sum_mant == '0);
    end
  end

  // ---------------- S2: normalize ----------------
  logic signed [9:0] w_exp_inc;
  logic signed [9:0] w_exp_dec;
  logic signed [9:0] w_n_exp;
  logic [26:0]       w_n_mant;
  states             w_n_state;

  assign w_exp_inc = $signed({2'b00, r1_sum.exp}) + 10'sd1;
  assign w_exp_dec = $signed({2'b00, r1_sum.exp}) - $signed({5'b0, r1_lzc});

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_n_state = OK;
    w_n_exp   = w_exp_dec;
    w_n_mant  = r1_sum.mant[26:0] << r1_lzc;
    if (r1_sum.st != OK) begin
      w_n_state = r1_sum.st;
    end else if (r1_carry) begin
      // The dropped LSB folds into sticky so rounding still sees it.
      w_n_mant = {r1_sum.mant[27:2], |r1_sum.mant[1:0]};
      w_n_exp  = w_exp_inc;
      if (w_exp_inc >= EXP_LIM) w_n_state = INF;
    end else if (r1_zero || w_exp_dec <= 10'sd0) begin
      w_n_state = NUL;
    end else if (w_exp_dec >= EXP_LIM) begin
      w_n_state = INF;
    end
  end

  logic              r2_sign;
  logic signed [9:0] r2_exp;
  logic [26:0]       r2_mant;
  states             r2_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_sign  <= 1'b0;
      r2_exp   <= '0;
      r2_mant  <= '0;
      r2_state <= OK;
    end else begin
      r2_sign  <= r1_sum.sign;
      r2_exp   <= w_n_exp;
      r2_mant  <= w_n_mant;
      r2_state <= w_n_state;
    end
  end

  // ---------------- S3: round and pack ----------------
  logic              w_round_up;
  logic [24:0]       w_rounded;
  logic [22:0]       w_frac;
  logic signed [9:0] w_fin_exp;
  logic [31:0]       w_res;
  states             w_st;

  assign w_round_up = r2_mant[2] & (r2_mant[1] | r2_mant[0] | r2_mant[3]);
  assign w_rounded  = {1'b0, r2_mant[26:3]} + 25'(w_round_up);
  // A carry-out leaves exactly 1.0, so the one-bit shift yields a zero fraction.
  assign w_frac     = w_rounded[24] ? w_rounded[23:1] : w_rounded[22:0];
  assign w_fin_exp  = r2_exp + (w_rounded[24] ? 10'sd1 : 10'sd0);

  always_comb begin
    w_res = {r2_sign, 31'h0};
    w_st  = r2_state;
    case (r2_state)
      OK: begin
        if (w_fin_exp >= EXP_LIM) begin
          w_res = {r2_sign, 8'hFF, 23'h0};
          w_st  = INF;
        end else begin
          w_res = {r2_sign, w_fin_exp[7:0], w_frac};
        end
      end
      NAN:     w_res = QNAN;
      INF:     w_res = {r2_sign, 8'hFF, 23'h0};
      default: ;
    endcase
  end

  logic [31:0] r3_result;
  states       r3_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_result <= '0;
      r3_state  <= OK;
    end else begin
      r3_result <= w_res;
      r3_state  <= w_st;
    end
  end

  assign result = r3_result;
  assign state  = r3_state;

  shift_reg_base #(.WIDTH(1), .STAGES(STAGES)) u_vld (
    .clk (clk),
    .rst (rst),
    .i_d (arg_vld),
    .o_q (res_vld)
  );

endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round: directed operands, bubble, reset flush.
module tb_fp_normalize_round;
  import float_struct::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sum_sign;
  logic [7:0]  sum_exp;
  logic [27:0] sum_mant;
  logic [1:0]  in_state;
  logic        arg_vld;
  logic [31:0] result;
  logic [1:0]  state;
  logic        res_vld;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [1:0]  st;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  fp_normalize_round #(.STAGES(3), .MANT_W(28)) dut (
    .clk      (clk),
    .rst      (rst),
    .sum_sign (sum_sign),
    .sum_exp  (sum_exp),
    .sum_mant (sum_mant),
    .in_state (in_state),
    .arg_vld  (arg_vld),
    .result   (result),
    .state    (state),
    .res_vld  (res_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Inputs change on the falling edge; the result is due three rising edges later.
  task automatic drive(input string tag, input logic s, input logic [7:0] e,
                       input logic [27:0] m, input logic [1:0] st,
                       input logic [31:0] want_res, input logic [1:0] want_st);
    @(negedge clk);
    sum_sign = s;
    sum_exp  = e;
    sum_mant = m;
    in_state = st;
    arg_vld  = 1'b1;
    sb.push_back('{tag: tag, res: want_res, st: want_st, exp_cyc: cyc + 3});
  endtask

  task automatic bubble();
    @(negedge clk);
    arg_vld  = 1'b0;
    sum_sign = 1'($urandom());
    sum_exp  = 8'($urandom());
    sum_mant = 28'($urandom());
    in_state = 2'($urandom());
  endtask

  always @(negedge clk) begin
    if (res_vld === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_vld", {31'b0, res_vld}, 32'd0);
      end else begin
        m_e = sb.pop_front();
        check({m_e.tag, "_lat"}, 32'(cyc), 32'(m_e.exp_cyc));
        check({m_e.tag, "_res"}, result, m_e.res);
        check({m_e.tag, "_st"}, {30'b0, state}, {30'b0, m_e.st});
      end
    end else if (sb.size() != 0 && sb[0].exp_cyc <= cyc) begin
      m_e = sb.pop_front();
      check({m_e.tag, "_vld"}, {31'b0, res_vld}, 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    arg_vld  = 1'b0;
    sum_sign = 1'b0;
    sum_exp  = '0;
    sum_mant = '0;
    in_state = OK;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res", result, 32'h0);
    check("rst_st", {30'b0, state}, 32'd0);
    check("rst_vld", {31'b0, res_vld}, 32'd0);
    rst = 1'b0;

    // Eight operands streamed with a bubble in slot 4.
    drive("carry",    1'b0, 8'd127, 28'h8000000, OK, 32'h40000000, OK);
    drive("cancel",   1'b0, 8'd127, 28'h0000008, OK, 32'h34000000, OK);
    drive("tie_even", 1'b0, 8'd127, 28'h4000004, OK, 32'h3F800000, OK);
    bubble();
    drive("tie_odd",  1'b0, 8'd127, 28'h400000C, OK, 32'h3F800002, OK);
    drive("all_ones", 1'b0, 8'd127, 28'h7FFFFFC, OK, 32'h40000000, OK);
    drive("ovf_pos",  1'b0, 8'd254, 28'h8000000, OK, 32'h7F800000, INF);
    drive("ovf_neg",  1'b1, 8'd254, 28'h8000000, OK, 32'hFF800000, INF);
    drive("uflow",    1'b0, 8'd5,   28'h0000008, OK, 32'h00000000, NUL);

    // Specials and boundaries.
    drive("nan",          1'b1, 8'd200, 28'h1234567, NAN, 32'h7FC00000, NAN);
    drive("zero_neg",     1'b1, 8'd100, 28'h0000000, OK,  32'h80000000, NUL);
    drive("inf_in",       1'b1, 8'd3,   28'h4000000, INF, 32'hFF800000, INF);
    drive("nul_in",       1'b0, 8'd127, 28'h4000000, NUL, 32'h00000000, NUL);
    drive("carry_sticky", 1'b0, 8'd127, 28'h8000009, OK,  32'h40000001, OK);
    drive("neg_norm",     1'b1, 8'd130, 28'h6000000, OK,  32'hC1400000, OK);
    drive("flush_edge",   1'b0, 8'd23,  28'h0000008, OK,  32'h00000000, NUL);
    drive("min_norm",     1'b0, 8'd24,  28'h0000008, OK,  32'h00800000, OK);
    drive("rnd_ovf",      1'b1, 8'd254, 28'h7FFFFFC, OK,  32'hFF800000, INF);
    drive("neg_flush",    1'b1, 8'd10,  28'h0000010, OK,  32'h80000000, NUL);
    bubble();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);

    // Two operands in flight, then reset; the operand offered during reset is ignored.
    @(negedge clk);
    sum_sign = 1'b0; sum_exp = 8'd127; sum_mant = 28'h8000000; in_state = OK; arg_vld = 1'b1;
    @(negedge clk);
    sum_sign = 1'b1; sum_exp = 8'd130; sum_mant = 28'h6000000; in_state = OK; arg_vld = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    sum_sign = 1'b1; sum_exp = 8'd254; sum_mant = 28'h8000000; in_state = INF; arg_vld = 1'b1;
    @(negedge clk);
    check("mid_rst_res", result, 32'h0);
    check("mid_rst_st", {30'b0, state}, 32'd0);
    check("mid_rst_vld", {31'b0, res_vld}, 32'd0);
    rst     = 1'b0;
    arg_vld = 1'b0;
    @(negedge clk);
    check("post_rst_res", result, 32'h0);
    check("post_rst_st", {30'b0, state}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_vld", {31'b0, res_vld}, 32'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Downstream neighbour of the floating-point adder: consumes the raw sign, exponent and unnormalized mantissa sum (with guard/round/sticky bits) plus the adder's classification code. It normalizes by leading-zero count or one-bit right shift, rounds to nearest-even and packs an IEEE-754 single-precision word. The block is a fixed 3-stage pipeline with a valid shift chain, no backpressure.

## Interface
- `STAGES`, 3: pipeline depth; fixed, other values unsupported.
- `MANT_W`, 28: input mantissa width.
  - bit 27 = carry.
  - bit 26 = hidden bit.
  - bits 25:3 = fraction.
  - bits 2:0 = guard, round, sticky.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `sum_sign`  in  1  sign of the sum.
- `sum_exp`  in  8  biased exponent of the larger operand.
- `sum_mant`  in  28  unnormalized magnitude, layout above.
- `in_state`  in  2  adder classification: OK=00, NAN=01, INF=10, NUL=11.
- `arg_vld`  in  1  inputs valid this cycle.
- `result`  out  32  packed float.
- `state`  out  2  final classification, same encoding.
- `res_vld`  out  1  `result`/`state` valid.

## Operation
- **S1 (capture):** register all inputs when `arg_vld`. Compute `lzc` = leading zeros of `sum_mant[26:0]`, range 0..27. Flag `carry` = bit 27 and `zero` = (`sum_mant` == 0).
- **S2 (normalize):** internal exponent is 10-bit signed.
  - `carry`: shift right 1; OR the shifted-out bit into sticky; exp+1.
  - `zero` with in_state OK: force NUL.
  - Otherwise: shift left by `lzc` (zeros fill); exp − `lzc`.
  - If exp − `lzc` ≤ 0 (no denormals): flush to ±0, state NUL.
- **S3 (round/pack):**
  - round_up = G & (R | S | fraction LSB).
  - A mantissa carry-out from rounding sets mantissa to 1.0 and exp+1.
  - exp ≥ 255 after normalize or round: result {sign, 8'hFF, 23'h0}, state INF.
- **Special passthrough** (in_state ≠ OK):
  - NAN → 32'h7FC00000, state NAN.
  - INF → {sum_sign, 31'h7F800000}, state INF.
  - NUL → {sum_sign, 31'h0}, state NUL.
- **Normal output:** {sign, exp[7:0], fraction[22:0]}, state OK.
- Sign is always preserved, including on flush-to-zero.

## Timing
- Latency is exactly 3 cycles: `arg_vld` sampled at edge k gives `res_vld`=1 after edge k+3.
- Throughput is one result per cycle; back-to-back `arg_vld` streams without bubbles.
- `res_vld` is a 3-deep shift of `arg_vld`. Data registers advance every cycle.
- Output data when `res_vld`=0 is don't-care but must be stable (no X after reset).
- Reset values: `result`=0, `state`=OK (00), `res_vld`=0. All pipeline registers and valid bits clear.
- Reset mid-operation drops all in-flight operations. `arg_vld` asserted in the same cycle as `rst` is ignored.
- Bubbles (`arg_vld`=0) propagate as `res_vld`=0 in the matching cycle.

## Structure
- **Shared package `float_struct`:**
  - the `states` enum (OK/NAN/INF/NUL).
  - constants `EXP_MAX`=255, `BIAS`=127, `QNAN`=32'h7FC00000.
  - an unpacked-sum struct {sign, exp[7:0], mant[27:0], st[1:0]} reused as the adder output type.
- **Sub-module `leading_zero_counter`:**
  - parameter `WIDTH`=27.
  - output width $clog2(WIDTH+1).
  - purely combinational, instantiated in S1.
- Valid chain reuses the existing `shift_reg_base` (`WIDTH`=1, `STAGES`=3).

## Test plan
1. **Carry normalize (1.0+1.0):** exp=127, mant=28'h8000000, OK → after 3 cycles 32'h40000000, OK.
2. **Massive cancellation:** exp=127, mant=28'h0000008 → lzc=23 → 32'h34000000, OK.
3. **Round to nearest-even:**
   - exp=127, mant=28'h4000004 (tie, LSB 0) → 32'h3F800000.
   - mant=28'h400000C (tie, LSB 1) → 32'h3F800002.
   - mant=28'h7FFFFFC (all-ones fraction, round up) → 32'h40000000.
4. **Overflow:** exp=254, mant=28'h8000000 → 32'h7F800000, INF. Sign=1 case → 32'hFF800000.
5. **Underflow and specials:**
   - exp=5, mant=28'h0000008 → 32'h00000000, NUL.
   - in_state=NAN → 32'h7FC00000, NAN.
   - zero mant with sign=1 → 32'h80000000, NUL.
6. **Streaming and reset:**
   - 8 back-to-back operands with a bubble in slot 4 → 8 results in order, with `res_vld` low in the matching slot.
   - `rst` pulsed with 2 operands in flight → `res_vld` stays 0 and outputs read 0/OK.
